// File: rtl/key_input_conditioner_if.sv
// Bus-facing signals of the key conditioner: raw key and clear strobes in,
// conditioned key status out. Names are from the conditioner's point of view.
interface key_input_conditioner_if #(
    parameter int CNT_W = 16
);
    logic             i_keyN;
    logic             i_clrEvt;
    logic             i_cntClr;
    logic             o_keyLevel;
    logic             o_keyPulse;
    logic             o_keyEvt;
    logic [CNT_W-1:0] o_pressCnt;

    modport master (
        output i_keyN, i_clrEvt, i_cntClr,
        input  o_keyLevel, o_keyPulse, o_keyEvt, o_pressCnt
    );

    modport slave (
        input  i_keyN, i_clrEvt, i_cntClr,
        output o_keyLevel, o_keyPulse, o_keyEvt, o_pressCnt
    );
endinterface

// File: rtl/key_input_conditioner.sv
// Push-button conditioner: synchronises the active-low key, debounces it with a
// 4-state FSM and exposes level, press pulse, sticky event flag and press counter.
module key_input_conditioner #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    key_input_conditioner_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        PRESSED,
        RELEASE_WAIT
    } state_t;

    localparam int              DB_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

    logic             r_sync1;
    logic             r_sync2;
    logic             w_keyS;
    state_t           r_state;
    logic [DB_W-1:0]  r_dbCnt;
    logic             r_keyLevel;
    logic             r_keyPulse;
    logic             r_keyEvt;
    logic [CNT_W-1:0] r_pressCnt;

    // Reset value 1 matches a released key so nothing fires while the chain fills.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= bus.i_keyN;
            r_sync2 <= r_sync1;
        end
    end

    assign w_keyS = ~r_sync2;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_dbCnt    <= '0;
            r_keyLevel <= 1'b0;
            r_keyPulse <= 1'b0;
        end else begin
            r_keyPulse <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_keyS) begin
                        r_state <= PRESS_WAIT;
                        r_dbCnt <= '0;
                    end
                end
                PRESS_WAIT: begin
                    if (!w_keyS) begin
                        r_state <= IDLE;
                        r_dbCnt <= '0;
                    end else if (r_dbCnt == DB_LAST) begin
                        r_state    <= PRESSED;
                        r_dbCnt    <= '0;
                        r_keyLevel <= 1'b1;
                        r_keyPulse <= 1'b1;
                    end else begin
                        r_dbCnt <= r_dbCnt + 1'b1;
                    end
                end
                PRESSED: begin
                    if (!w_keyS) begin
                        r_state <= RELEASE_WAIT;
                        r_dbCnt <= '0;
                    end
                end
                RELEASE_WAIT: begin
                    // A bounce back to pressed keeps the level high and emits no new pulse.
                    if (w_keyS) begin
                        r_state <= PRESSED;
                        r_dbCnt <= '0;
                    end else if (r_dbCnt == DB_LAST) begin
                        r_state    <= IDLE;
                        r_dbCnt    <= '0;
                        r_keyLevel <= 1'b0;
                    end else begin
                        r_dbCnt <= r_dbCnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_dbCnt <= '0;
                end
            endcase
        end
    end

    // A press always beats a simultaneous software clear, so no press is lost.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_keyEvt   <= 1'b0;
            r_pressCnt <= '0;
        end else begin
            if (r_keyPulse) begin
                r_keyEvt <= 1'b1;
            end else if (bus.i_clrEvt) begin
                r_keyEvt <= 1'b0;
            end

            if (bus.i_cntClr) begin
                r_pressCnt <= r_keyPulse ? CNT_W'(1) : '0;
            end else if (r_keyPulse) begin
                r_pressCnt <= r_pressCnt + 1'b1;
            end
        end
    end

    assign bus.o_keyLevel = r_keyLevel;
    assign bus.o_keyPulse = r_keyPulse;
    assign bus.o_keyEvt   = r_keyEvt;
    assign bus.o_pressCnt = r_pressCnt;
endmodule
